// File: rtl/usb_line_pkg.sv
// Shared line-state, FSM and widths for the USB NRZI transmit encoder.
package usb_line_pkg;

  typedef enum logic [1:0] {
    J   = 2'b10,
    K   = 2'b01,
    SE0 = 2'b00
  } line_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  // SYNC byte, transmitted LSB first: seven zeros then a one.
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  localparam int unsigned RUN_W  = 4;
  localparam int unsigned EOP_W  = 3;
  localparam int unsigned SYNC_W = 3;

  // Low-speed links swap the J and K encodings; SE0 is unaffected.
  function automatic line_t apply_polarity(input line_t l, input logic swap);
    line_t r;
    r = l;
    if (swap) begin
      if (l == J) begin
        r = K;
      end else if (l == K) begin
        r = J;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nrzi_stuff_cnt.sv
// Counts consecutive ones; flags when the next one would complete a stuff run.
module nrzi_stuff_cnt
  import usb_line_pkg::*;
#(
  parameter int unsigned STUFF_RUN = 6,
  parameter bit          STUFF_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic stuff_due_o
);

  logic [RUN_W-1:0] ones_q, ones_d;
  logic             stuff_due_q, stuff_due_d;

  // Next run length (saturating) and look-ahead stuff flag.
  always_comb begin
    ones_d = ones_q;
    if (clr_i) begin
      ones_d = '0;
    end else if (inc_i && (ones_q != '1)) begin
      ones_d = ones_q + RUN_W'(1);
    end
    stuff_due_d = STUFF_EN && (ones_d == RUN_W'(STUFF_RUN - 1));
  end

  // Run-length register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q      <= '0;
      stuff_due_q <= 1'b0;
    end else begin
      ones_q      <= ones_d;
      stuff_due_q <= stuff_due_d;
    end
  end

  assign stuff_due_o = stuff_due_q;

endmodule

// File: rtl/nrzi_tx_ctrl.sv
// USB transmit line encoder: SYNC generation, bit stuffing, NRZI and EOP.
module nrzi_tx_ctrl
  import usb_line_pkg::*;
#(
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter bit          STUFF_EN     = 1'b1,
  parameter int unsigned STUFF_RUN    = 6,
  parameter bit          SYNC_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       low_speed,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       bit_last,
  output logic       bit_ready,
  output logic [1:0] out,
  output logic       busy,
  output logic       done,
  output logic       stuffed,
  output logic       err_underrun
);

  tx_state_t         state_q, state_d;
  line_t             out_q, out_d;
  logic              lvl_j_q, lvl_j_d;      // NRZI level, 1 = J
  logic              pol_q, pol_d;          // latched low_speed
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [EOP_W-1:0]  eop_cnt_q, eop_cnt_d;
  logic              last_q, last_d;        // final data bit already taken
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stuffed_q, stuffed_d;
  logic              err_q, err_d;
  logic              cnt_clr, cnt_inc, stuff_due;

  nrzi_stuff_cnt #(
    .STUFF_RUN (STUFF_RUN),
    .STUFF_EN  (STUFF_EN)
  ) u_stuff_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (cnt_clr),
    .inc_i       (cnt_inc),
    .stuff_due_o (stuff_due)
  );

  // Next state and the line bit to drive after the coming edge.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    lvl_j_d    = lvl_j_q;
    pol_d      = pol_q;
    sync_cnt_d = sync_cnt_q;
    eop_cnt_d  = eop_cnt_q;
    last_d     = last_q;
    done_d     = 1'b0;
    stuffed_d  = 1'b0;
    err_d      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        lvl_j_d = 1'b1;
        out_d   = apply_polarity(J, pol_q);
        if (start && !busy_q) begin
          pol_d     = low_speed;
          cnt_clr   = 1'b1;
          last_d    = 1'b0;
          eop_cnt_d = '0;
          if (SYNC_EN) begin
            state_d    = SYNC;
            lvl_j_d    = SYNC_PATTERN[0];
            out_d      = apply_polarity(lvl_j_d ? J : K, pol_d);
            sync_cnt_d = SYNC_W'(1);
          end else begin
            state_d = DATA;
            out_d   = apply_polarity(J, pol_d);
          end
        end
      end

      SYNC: begin
        lvl_j_d    = SYNC_PATTERN[sync_cnt_q] ? lvl_j_q : !lvl_j_q;
        out_d      = apply_polarity(lvl_j_d ? J : K, pol_q);
        cnt_inc    = SYNC_PATTERN[sync_cnt_q];
        cnt_clr    = !SYNC_PATTERN[sync_cnt_q];
        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
        if (sync_cnt_q == SYNC_W'(7)) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_valid) begin
          lvl_j_d = bit_in ? lvl_j_q : !lvl_j_q;
          out_d   = apply_polarity(lvl_j_d ? J : K, pol_q);
          cnt_inc = bit_in;
          cnt_clr = !bit_in;
          last_d  = bit_last;
          if (bit_in && stuff_due) begin
            state_d = STUFF;
          end else if (bit_last) begin
            state_d = EOP_SE0;
          end
        end else begin
          // Underrun: the first SE0 of the EOP goes out on this edge.
          err_d = 1'b1;
          out_d = SE0;
          if (EOP_SE0_BITS <= 1) begin
            state_d = EOP_J;
          end else begin
            state_d   = EOP_SE0;
            eop_cnt_d = EOP_W'(1);
          end
        end
      end

      STUFF: begin
        lvl_j_d   = !lvl_j_q;
        out_d     = apply_polarity(lvl_j_d ? J : K, pol_q);
        stuffed_d = 1'b1;
        cnt_clr   = 1'b1;
        state_d   = last_q ? EOP_SE0 : DATA;
      end

      EOP_SE0: begin
        out_d = SE0;
        if (eop_cnt_q == EOP_W'(EOP_SE0_BITS - 1)) begin
          eop_cnt_d = '0;
          state_d   = EOP_J;
        end else begin
          eop_cnt_d = eop_cnt_q + EOP_W'(1);
        end
      end

      EOP_J: begin
        lvl_j_d = 1'b1;
        out_d   = apply_polarity(J, pol_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == DATA);
    busy_d  = (state_d != IDLE) || (state_q == EOP_J);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      out_q      <= J;
      lvl_j_q    <= 1'b1;
      pol_q      <= 1'b0;
      sync_cnt_q <= '0;
      eop_cnt_q  <= '0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stuffed_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      lvl_j_q    <= lvl_j_d;
      pol_q      <= pol_d;
      sync_cnt_q <= sync_cnt_d;
      eop_cnt_q  <= eop_cnt_d;
      last_q     <= last_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stuffed_q  <= stuffed_d;
      err_q      <= err_d;
    end
  end

  assign bit_ready    = ready_q;
  assign out          = out_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign stuffed      = stuffed_q;
  assign err_underrun = err_q;

endmodule

// File: doc/nrzi_tx_ctrl.md
Name: nrzi_tx_ctrl

Overview:
Parametrised next-generation USB transmit line encoder. Accepts a serial bit stream over a valid/ready handshake and optionally generates SYNC itself. Performs bit stuffing and NRZI encoding, supports full- and low-speed line polarity, and terminates every packet with a configurable-length EOP. Sits between the packet serialiser and the differential pad driver.

Parameters:
EOP_SE0_BITS, 2, number of SE0 bit-times in EOP (1..7)
STUFF_EN, 1, 1 = insert stuff bit after STUFF_RUN consecutive ones; 0 = no stuffing
STUFF_RUN, 6, run length of ones that triggers a stuff bit (2..15)
SYNC_EN, 1, 1 = block emits 8-bit SYNC (00000001, LSB first) before data; 0 = data starts immediately

Ports:
clk  in  1  bit-time clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a packet; ignored while busy
low_speed  in  1  sampled with start; 1 swaps J/K encodings for the whole packet
bit_in  in  1  data bit, LSB-first stream
bit_valid  in  1  bit_in valid
bit_last  in  1  qualifies bit_in as final data bit
bit_ready  out  1  block consumes bit_in this cycle
out  out  2  line state: J=2'b10, K=2'b01, SE0=2'b00 (J/K swapped when low_speed)
busy  out  1  high from cycle after start until return to IDLE
done  out  1  one-cycle pulse on EOP completion
stuffed  out  1  high during any cycle emitting a stuff bit
err_underrun  out  1  one-cycle pulse when bit_valid is low in a DATA cycle

Behaviour:
- Reset (async, any state): state=IDLE, out=J (2'b10), bit_ready=0, busy=0, done=0, stuffed=0, err_underrun=0, ones counter=0, latched polarity=full speed.
- One line bit per clk. out is registered: the bit decided at edge t is driven after edge t.
- NRZI: a 0 toggles J<->K, a 1 holds the previous J/K. The prior state at packet start is J (idle).
- States: IDLE -> SYNC (SYNC_EN=1) or DATA -> [STUFF] -> EOP_SE0 -> EOP_J -> IDLE.
- IDLE: out=J. start=1 latches low_speed and moves to SYNC or DATA; the first line bit appears the cycle after start.
- SYNC: 8 cycles emitting bits 0,0,0,0,0,0,0,1, giving line KJKJKJKK. bit_ready=0. The final 1 counts toward the stuff run (ones=1).
- DATA: bit_ready=1 unless a stuff bit is due. On bit_valid&bit_ready, encode bit_in and update ones (1: ones+1, 0: ones=0).
  - bit_last accepted: go to EOP_SE0, or to STUFF first if that bit completes a run.
- STUFF (STUFF_EN=1, ones==STUFF_RUN): emit a 0 (toggle), stuffed=1, bit_ready=0, ones=0, then return to DATA (or EOP_SE0 if the last bit was already taken).
  - A stuff bit owed after the last data bit is always sent before EOP.
- Underrun: bit_valid=0 in a DATA cycle with bit_ready=1. Pulse err_underrun and go directly to EOP_SE0 in that cycle. No further bits are consumed.
- EOP_SE0: out=SE0 for EOP_SE0_BITS cycles (3-bit counter, cleared on exit).
- EOP_J: out=J for 1 cycle, done=1 in this cycle. Next state IDLE; busy drops in IDLE.
- start while busy: ignored, with no side effects. low_speed changes mid-packet: ignored.
- STUFF_EN=0: the STUFF state is unreachable and ones is unused.
- SE0 encoding is unaffected by low_speed. Idle J uses the latched polarity after the first packet; reset restores full speed.

Decomposition:
- Package usb_line_pkg:
  - line_t enum {J=2'b10, K=2'b01, SE0=2'b00}
  - tx_state_t enum {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J}
  - SYNC_PATTERN=8'h80 (sent LSB first)
  - polarity-swap function
- Sub-module nrzi_stuff_cnt: ones-run counter with clear, inc and stuff_due output, parametrised by STUFF_RUN.

Test Plan:
- SYNC_EN=1, start, data byte 8'h00 LSB-first with bit_last on the 8th bit -> out = KJKJKJKK, JKJKJKJK, SE0, SE0, J. done high on the J cycle; busy low the next cycle.
- Data 8'hFF -> after SYNC: K,K,K,K,K, then J with stuffed=1 and bit_ready=0, then J,J,J, SE0,SE0, J. Exactly 8 bits consumed.
- low_speed=1 at start, data 8'h00 -> same sequence as test 1 with J=2'b01 and K=2'b10. Toggling low_speed mid-packet has no effect.
- Drop bit_valid after 3 data bits -> err_underrun pulses once, then SE0 x EOP_SE0_BITS, J, done. Further valid bits are not consumed.
- Assert rst during DATA -> out=2'b10 immediately (asynchronous), busy=0, no done pulse. A new start after rst release produces a full SYNC.
- EOP_SE0_BITS=3, STUFF_EN=0, data 8'hFF -> 8 K bits with no stuff, then SE0 x3, J. A start pulsed during EOP is ignored.
